// File: rtl/p3_cache_pkg.sv
// Shared definitions for the cache miss/write-back sequencer:
// bus widths, default memory latency, FSM state encodings and helpers.
package p3_cache_pkg;

   localparam int ADDR_W          = 5;
   localparam int DATA_W          = 8;
   localparam int CACHE_DATA_BITS = 3;   // low data bits actually held by the cache
   localparam int MEM_LAT         = 7;   // default memory latency in cycles
   localparam int LAT_W           = 4;   // latency counter width (MEM_LAT 1..15)
   localparam int CNT_W           = 8;   // statistics counter width

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_CHECK  = 3'd2,
      ST_WB     = 3'd3,
      ST_RD     = 3'd4,
      ST_FILL   = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // Saturating increment: statistics stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/p3_lat_counter.sv
// Down-counter timing memory accesses. Loaded with latency-1 on entry to a
// memory state, it decrements each cycle and flags zero on the final cycle.
module p3_lat_counter
   import p3_cache_pkg::*;
(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [LAT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [LAT_W-1:0] r_count;

   // Load takes priority so back-to-back WB->RD reloads cleanly; stop at zero.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)
         r_count <= '0;
      else if (i_load)
         r_count <= i_load_val;
      else if (i_dec && (r_count != '0))
         r_count <= r_count - 1'b1;
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/p3_cache_ctrl.sv
// Miss/write-back sequencer between the requester, a 2-way write-back cache
// and main memory. One request at a time: lookup, optional dirty-victim
// write-back, refill, fill commit, completion pulse. Keeps hit/miss/wb stats.
module p3_cache_ctrl #(
   parameter int MEM_LAT = p3_cache_pkg::MEM_LAT,
   parameter int ADDR_W  = p3_cache_pkg::ADDR_W,
   parameter int DATA_W  = p3_cache_pkg::DATA_W
)(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_cpu_req,
   input  logic              i_cpu_wren,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ready,
   output logic              o_cpu_done,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_cache_lookup,
   output logic              o_cache_wren,
   output logic [ADDR_W-1:0] o_cache_addr,
   output logic [DATA_W-1:0] o_cache_wdata,
   input  logic              i_cache_hit,
   input  logic              i_cache_victim_dirty,
   input  logic [ADDR_W-1:0] i_cache_victim_addr,
   input  logic [DATA_W-1:0] i_cache_victim_data,
   input  logic [DATA_W-1:0] i_cache_rdata,
   output logic              o_cache_fill,
   output logic [DATA_W-1:0] o_cache_fill_data,
   output logic              o_cache_fill_dirty,
   output logic              o_mem_en,
   output logic              o_mem_wren,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy,
   output logic [7:0]        o_hit_cnt,
   output logic [7:0]        o_miss_cnt,
   output logic [7:0]        o_wb_cnt,
   output logic [2:0]        o_state_dbg
);

   import p3_cache_pkg::*;

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

   state_t            r_state;
   logic              r_req_wren;
   logic              r_cpu_ready;
   logic              r_cpu_done;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic              r_cache_lookup;
   logic              r_cache_wren;
   logic [ADDR_W-1:0] r_cache_addr;
   logic [DATA_W-1:0] r_cache_wdata;
   logic              r_cache_fill;
   logic [DATA_W-1:0] r_cache_fill_data;
   logic              r_cache_fill_dirty;
   logic              r_mem_en;
   logic              r_mem_wren;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_busy;
   logic [CNT_W-1:0]  r_hit_cnt;
   logic [CNT_W-1:0]  r_miss_cnt;
   logic [CNT_W-1:0]  r_wb_cnt;

   logic              w_lat_load;
   logic              w_lat_dec;
   logic              w_lat_zero;
   logic [DATA_W-1:0] w_fill_data;

   // Counter reloads on entry to WB (from CHECK) and on entry to RD
   // (from CHECK on a clean miss, or from the last WB cycle).
   assign w_lat_load = ((r_state == ST_CHECK) && !i_cache_hit) ||
                       ((r_state == ST_WB) && w_lat_zero);
   assign w_lat_dec  = (r_state == ST_WB) || (r_state == ST_RD);

   p3_lat_counter u_lat (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_load     (w_lat_load),
      .i_load_val (LAT_LOAD),
      .i_dec      (w_lat_dec),
      .o_zero     (w_lat_zero)
   );

   // Fill line: a write-allocate merges the cached low bits of the write data
   // over the refilled word; a read installs the memory word unchanged.
   generate
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fill
         if (gi < CACHE_DATA_BITS) begin : g_merge
            assign w_fill_data[gi] = r_req_wren ? r_cache_wdata[gi] : i_mem_rdata[gi];
         end else begin : g_mem
            assign w_fill_data[gi] = i_mem_rdata[gi];
         end
      end
   endgenerate

   // Sequencer FSM; every output is a register updated on the transition edge.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state            <= ST_IDLE;
         r_req_wren         <= 1'b0;
         r_cpu_ready        <= 1'b0;
         r_cpu_done         <= 1'b0;
         r_cpu_rdata        <= '0;
         r_cache_lookup     <= 1'b0;
         r_cache_wren       <= 1'b0;
         r_cache_addr       <= '0;
         r_cache_wdata      <= '0;
         r_cache_fill       <= 1'b0;
         r_cache_fill_data  <= '0;
         r_cache_fill_dirty <= 1'b0;
         r_mem_en           <= 1'b0;
         r_mem_wren         <= 1'b0;
         r_mem_addr         <= '0;
         r_mem_wdata        <= '0;
         r_busy             <= 1'b0;
         r_hit_cnt          <= '0;
         r_miss_cnt         <= '0;
         r_wb_cnt           <= '0;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         r_cpu_done     <= 1'b0;
         r_cache_lookup <= 1'b0;
         r_cache_wren   <= 1'b0;
         r_cache_fill   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cpu_ready <= 1'b1;
               if (i_cpu_req && r_cpu_ready) begin
                  r_req_wren     <= i_cpu_wren;
                  r_cache_addr   <= i_cpu_addr;
                  r_cache_wdata  <= i_cpu_wdata;
                  r_cache_lookup <= 1'b1;
                  r_cache_wren   <= i_cpu_wren;
                  r_cpu_ready    <= 1'b0;
                  r_busy         <= 1'b1;
                  r_state        <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               r_state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (i_cache_hit) begin
                  r_cpu_rdata <= r_req_wren ? r_cache_wdata : i_cache_rdata;
                  r_hit_cnt   <= sat_inc(r_hit_cnt);
                  r_cpu_done  <= 1'b1;
                  r_state     <= ST_DONE;
               end else if (i_cache_victim_dirty) begin
                  r_miss_cnt  <= sat_inc(r_miss_cnt);
                  r_wb_cnt    <= sat_inc(r_wb_cnt);
                  r_mem_en    <= 1'b1;
                  r_mem_wren  <= 1'b1;
                  r_mem_addr  <= i_cache_victim_addr;
                  r_mem_wdata <= i_cache_victim_data;
                  r_state     <= ST_WB;
               end else begin
                  r_miss_cnt  <= sat_inc(r_miss_cnt);
                  r_mem_en    <= 1'b1;
                  r_mem_wren  <= 1'b0;
                  r_mem_addr  <= r_cache_addr;
                  r_state     <= ST_RD;
               end
            end
            ST_WB: begin
               if (w_lat_zero) begin
                  r_mem_wren <= 1'b0;
                  r_mem_addr <= r_cache_addr;
                  r_state    <= ST_RD;
               end
            end
            ST_RD: begin
               if (w_lat_zero) begin
                  r_mem_en           <= 1'b0;
                  r_cache_fill       <= 1'b1;
                  r_cache_fill_data  <= w_fill_data;
                  r_cache_fill_dirty <= r_req_wren;
                  r_state            <= ST_FILL;
               end
            end
            ST_FILL: begin
               r_cpu_rdata <= r_cache_fill_data;
               r_cpu_done  <= 1'b1;
               r_state     <= ST_DONE;
            end
            ST_DONE: begin
               r_cpu_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_busy   <= 1'b0;
               r_mem_en <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_cpu_ready        = r_cpu_ready;
   assign o_cpu_done         = r_cpu_done;
   assign o_cpu_rdata        = r_cpu_rdata;
   assign o_cache_lookup     = r_cache_lookup;
   assign o_cache_wren       = r_cache_wren;
   assign o_cache_addr       = r_cache_addr;
   assign o_cache_wdata      = r_cache_wdata;
   assign o_cache_fill       = r_cache_fill;
   assign o_cache_fill_data  = r_cache_fill_data;
   assign o_cache_fill_dirty = r_cache_fill_dirty;
   assign o_mem_en           = r_mem_en;
   assign o_mem_wren         = r_mem_wren;
   assign o_mem_addr         = r_mem_addr;
   assign o_mem_wdata        = r_mem_wdata;
   assign o_busy             = r_busy;
   assign o_hit_cnt          = r_hit_cnt;
   assign o_miss_cnt         = r_miss_cnt;
   assign o_wb_cnt           = r_wb_cnt;
   assign o_state_dbg        = r_state;

endmodule

// File: doc/p3_cache_ctrl.md
# p3_cache_ctrl

Miss/write-back sequencer that sits between the requester (CPU-side circuit), the 2-way write-back cache and the main memory. It accepts one read or write request at a time and drives the cache lookup. On a miss it runs the dirty-victim write-back, then the memory refill, each with a fixed memory latency. It then commits the fill into the cache and returns completion to the requester. It replaces the ad-hoc `atualiza`/`readMemDone` sequencing inside the cache with an explicit FSM, and adds hit/miss/write-back statistics.

## Interface
Parameters:
- MEM_LAT, 7, memory access latency in cycles per read or write; legal range 1..15
- ADDR_W, 5, address width
- DATA_W, 8, data bus width; the cache stores bits [2:0]

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_req  in  1  request valid
- cpu_wren  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  request address
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  high only in IDLE; a request is accepted when cpu_req & cpu_ready
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read result, valid with cpu_done, held until the next done
- cache_lookup  out  1  one-cycle lookup strobe
- cache_wren  out  1  latched cpu_wren, qualified by cache_lookup
- cache_addr  out  ADDR_W  latched request address
- cache_wdata  out  DATA_W  latched write data
- cache_hit  in  1  lookup result, sampled in CHECK
- cache_victim_dirty  in  1  LRU victim is valid and dirty, sampled in CHECK
- cache_victim_addr  in  ADDR_W  victim address {tag, index}, sampled in CHECK
- cache_victim_data  in  DATA_W  victim data, sampled in CHECK
- cache_rdata  in  DATA_W  hit data, sampled in CHECK
- cache_fill  out  1  one-cycle strobe to install the refilled line
- cache_fill_data  out  DATA_W  data to install
- cache_fill_dirty  out  1  1 when the fill is a write-allocate
- mem_en  out  1  memory access active
- mem_wren  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write-back data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- hit_cnt  out  8  hit statistics counter
- miss_cnt  out  8  miss statistics counter
- wb_cnt  out  8  write-back statistics counter
- state_dbg  out  3  current FSM state encoding

## Operation
- FSM states: IDLE(0), LOOKUP(1), CHECK(2), WB(3), RD(4), FILL(5), DONE(6).
- IDLE: cpu_ready=1. On cpu_req, latch addr, wren and wdata, then go to LOOKUP. cpu_req while busy is ignored; there is no queue.
- LOOKUP: cache_lookup=1 for one cycle. The cache performs hit-write internally. Go to CHECK.
- CHECK: sample the cache_* inputs.
  - Hit: cpu_rdata ← cache_rdata for a read or the latched wdata for a write; hit_cnt++; go to DONE.
  - Miss with dirty victim: latch victim addr/data; miss_cnt++, wb_cnt++; go to WB.
  - Miss with clean victim: miss_cnt++; go to RD.
- WB: mem_en=1, mem_wren=1, mem_addr=victim addr, mem_wdata=victim data, held for exactly MEM_LAT cycles, then go to RD.
- RD: mem_en=1, mem_wren=0, mem_addr=request addr, held for MEM_LAT cycles. mem_rdata is captured on the last RD cycle. Go to FILL.
- FILL: cache_fill=1 for one cycle.
  - Read: fill_data=mem_rdata, fill_dirty=0, cpu_rdata=mem_rdata.
  - Write: fill_data={mem_rdata[7:3], wdata[2:0]}, fill_dirty=1, cpu_rdata=fill_data.
  - Go to DONE.
- DONE: cpu_done=1, then go to IDLE.
- Counters: 8-bit, saturate at 255 with no wrap.
- Latency counter: 4-bit, loaded with MEM_LAT-1 on entry to WB and to RD, decrements each cycle, and the state exits at 0.

## Timing
- Accept edge is T. Then LOOKUP is T+1, CHECK is T+2.
- Hit: DONE at T+3, so total latency is 3 cycles.
- Clean miss: RD at T+3..T+2+L, FILL at T+3+L, DONE at T+4+L.
- Dirty miss: adds L cycles of WB before RD; DONE at T+4+2L.
- cpu_ready is low from T+1 through DONE and returns high the cycle after DONE. Back-to-back requests therefore have a minimum spacing of 4 cycles.
- All outputs are registered. Reset value of every output and counter is 0, and the state is IDLE.
- Reset mid-operation: return to IDLE immediately. The in-flight request is dropped: no cpu_done, no cache_fill, and mem_en drops asynchronously.
- MEM_LAT=1: WB and RD each last exactly one cycle.
- A request presented in the DONE cycle is not accepted; it is accepted the following cycle if it is still held.

## Structure
- Package p3_cache_pkg holds:
  - the state enum and its encodings;
  - ADDR_W, DATA_W and CACHE_DATA_BITS=3;
  - the default MEM_LAT=7.
- Sub-module p3_lat_counter: load/decrement/zero-flag down-counter shared by WB and RD.

## Test plan
- Read hit: addr 5'b00001 hits with cache_rdata=8'h03 → cpu_done at T+3, cpu_rdata=8'h03, hit_cnt=1, mem_en never asserted.
- Clean read miss, MEM_LAT=7, mem_rdata=8'h05 → mem_en with mem_wren=0 for 7 cycles, cache_fill with data 8'h05 and fill_dirty=0, cpu_done at T+11, miss_cnt=1.
- Dirty write miss, victim addr 5'b10011 with data 8'h03, cpu_wdata=8'h06, mem_rdata=8'hF8:
  - 7 cycles with mem_wren=1 at addr 5'b10011 and wdata 8'h03, then 7 read cycles;
  - fill_data=8'hFE with fill_dirty=1;
  - cpu_done at T+18, wb_cnt=1.
- Assert reset during cycle 3 of WB → busy=0, mem_en=0 immediately; no cpu_done and no cache_fill; counters read 0.
- 260 back-to-back hits → hit_cnt saturates at 255. Requests held during busy are accepted exactly once each.
